// File: rtl/fadd_issue_if.sv
// fadd_issue_if: request/response handshake bundle between a requester and fadd_issue
interface fadd_issue_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_op1;
  logic [31:0]      req_op2;
  logic             req_sub;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  modport master (
    output req_valid, req_op1, req_op2, req_sub, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );
  modport slave (
    input  req_valid, req_op1, req_op2, req_sub, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );
endinterface

// File: rtl/fadd_issue.sv
// fadd_issue: issue/retire controller around a fixed-latency pipelined fadd unit
module fadd_issue #(
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  fadd_issue_if.slave io,
  output logic [31:0] fa_op1,
  output logic [31:0] fa_op2,
  input  logic [31:0] fa_result
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]             outstanding_q, outstanding_d, wr_q, wr_d, rd_q, rd_d;
  logic [LAT:0]            vld_q, vld_d;
  logic [LAT:0][TAG_W-1:0] tag_q, tag_d;
  logic [31:0]             op1_q, op2_q;
  logic [31:0]             res_q [DEPTH];
  logic [TAG_W-1:0]        rtag_q [DEPTH];
  logic                    accept, pop, push;
  // credits cover in-flight plus buffered ops, so a push can never hit a full FIFO
  assign io.req_ready  = outstanding_q < (AW+1)'(DEPTH);
  assign io.rsp_valid  = wr_q != rd_q;
  assign io.rsp_result = res_q[rd_q[AW-1:0]];
  assign io.rsp_tag    = rtag_q[rd_q[AW-1:0]];
  assign fa_op1        = op1_q;
  assign fa_op2        = op2_q;
  assign accept        = io.req_valid & io.req_ready;
  assign pop           = io.rsp_valid & io.rsp_ready;
  assign push          = vld_q[LAT];
  always_comb begin
    outstanding_d = outstanding_q + (AW+1)'(accept) - (AW+1)'(pop);
    vld_d         = {vld_q[LAT-1:0], accept};
    tag_d         = {tag_q[LAT-1:0], io.req_tag};
    wr_d          = wr_q + (AW+1)'(push);
    rd_d          = rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      vld_q         <= '0;
      tag_q         <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i]  <= '0;
        rtag_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      vld_q         <= vld_d;
      tag_q         <= tag_d;
      if (accept) begin
        op1_q <= io.req_op1;
        op2_q <= {io.req_op2[31] ^ io.req_sub, io.req_op2[30:0]};
      end
      if (push) begin
        res_q[wr_q[AW-1:0]]  <= fa_result;
        rtag_q[wr_q[AW-1:0]] <= tag_q[LAT];
      end
    end
  end
endmodule

// File: tb/tb_fadd_issue.sv
// tb_fadd_issue: directed + random scoreboard bench for fadd_issue with a behavioural fadd pipeline
module tb_fadd_issue;
  localparam int LAT = 3, DEPTH = 8, TAG_W = 5;
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    bit               exact;
  } exp_t;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] fa_op1, fa_op2, fa_result;
  logic [31:0] p1, p2, p3;
  exp_t        sb[$];
  exp_t        pend;
  int          errors = 0, checks = 0, n_acc = 0, n_pop = 0;

  fadd_issue_if #(.TAG_W(TAG_W)) bus ();
  fadd_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .io(bus),
    .fa_op1(fa_op1), .fa_op2(fa_op2), .fa_result(fa_result)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = (f[30:0] == 0) ? {f[31], 63'd0} : {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic        up;
    d  = $realtobits(r);
    up = d[28] & ((|d[27:0]) | d[29]);
    if (d[62:0] == 0) return {d[63], 31'd0};
    return {d[63], {8'(d[62:52] - 11'd896), d[51:29]} + 31'(up)};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    return r2f(s ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  // LAT-stage fadd: operands present after edge k give a result after edge k+LAT
  always @(posedge clk) begin
    p1 <= r2f(f2r(fa_op1) + f2r(fa_op2));
    p2 <= p1;
    p3 <= p2;
  end
  assign fa_result = p3;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
    end
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [TAG_W-1:0] t, input logic [31:0] r, input bit ex);
    bus.req_valid = 1;
    bus.req_op1   = a;
    bus.req_op2   = b;
    bus.req_sub   = s;
    bus.req_tag   = t;
    pend.tag      = t;
    pend.res      = r;
    pend.exact    = ex;
  endtask

  task automatic cyc();
    exp_t    e;
    longint  d;
    @(negedge clk);
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_pop++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed tag=%0d expected no response", bus.rsp_tag);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
        if (e.exact) chk("rsp_result", bus.rsp_result, e.res);
        else begin
          d = longint'(bus.rsp_result) - longint'(e.res);
          checks++;
          assert (d >= -1 && d <= 1) else begin
            errors++;
            $error("FAIL rsp_result_ulp observed=%h expected=%h", bus.rsp_result, e.res);
          end
        end
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      sb.push_back(pend);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) cyc();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int a0, p0;
    logic [31:0] a, b;
    logic s;
    bus.req_valid = 0;
    bus.req_op1   = 0;
    bus.req_op2   = 0;
    bus.req_sub   = 0;
    bus.req_tag   = 0;
    bus.rsp_ready = 0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_tag", 32'(bus.rsp_tag), 0);
    chk("rst_fa_op1", fa_op1, 0);
    chk("rst_fa_op2", fa_op2, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_req_ready", 32'(bus.req_ready), 1);

    // add: result appears exactly LAT+1 edges after accept, for one cycle
    bus.rsp_ready = 1;
    set_req(32'h3F800000, 32'h40000000, 0, 3, 32'h40400000, 1);
    cyc();
    bus.req_valid = 0;
    chk("add_fa_op1", fa_op1, 32'h3F800000);
    chk("add_fa_op2", fa_op2, 32'h40000000);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("add_lat_low", 32'(bus.rsp_valid), 0);
    end
    cyc();
    chk("add_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("add_rsp_result", bus.rsp_result, 32'h40400000);
    chk("add_rsp_tag", 32'(bus.rsp_tag), 3);
    cyc();
    chk("add_rsp_once", 32'(bus.rsp_valid), 0);

    // subtract flips op2 sign
    set_req(32'h40400000, 32'h3F800000, 1, 7, 32'h40000000, 1);
    cyc();
    bus.req_valid = 0;
    chk("sub_fa_op2", fa_op2, 32'hBF800000);
    drain();

    // backpressure
    bus.rsp_ready = 0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      a = 32'h3F800000 + (32'(i) << 23);
      set_req(a, 32'h3F800000, 0, 5'(i), model(a, 32'h3F800000, 0), 1);
      chk("bp_ready", 32'(bus.req_ready), 1);
      cyc();
    end
    chk("bp_full_ready", 32'(bus.req_ready), 0);
    a = 32'h43000000;
    set_req(a, 32'h3F800000, 1, 8, model(a, 32'h3F800000, 1), 1);
    repeat (5) cyc();
    chk("bp_accepted8", 32'(n_acc - a0), 8);
    chk("bp_still_full", 32'(bus.req_ready), 0);
    bus.rsp_ready = 1;
    cyc();
    chk("bp_ready_after_pop", 32'(bus.req_ready), 1);
    chk("bp_no_accept_at_pop", 32'(n_acc - a0), 8);
    cyc();
    set_req(a, 32'h40000000, 0, 9, model(a, 32'h40000000, 0), 1);
    cyc();
    bus.req_valid = 0;
    chk("bp_accepted10", 32'(n_acc - a0), 10);
    drain();

    // streaming random ops, wraps the FIFO many times
    p0 = n_pop;
    bus.rsp_ready = 1;
    for (int i = 0; i < 100; i++) begin
      a = rnd();
      b = rnd();
      s = 1'($urandom_range(0, 1));
      set_req(a, b, s, 5'(i), model(a, b, s), 0);
      chk("st_req_ready", 32'(bus.req_ready), 1);
      cyc();
      if (i >= 4) chk("st_rsp_valid", 32'(bus.rsp_valid), 1);
    end
    drain();
    chk("st_pops", 32'(n_pop - p0), 100);

    // full plus same-cycle pop: no accept until the edge after the pop
    bus.rsp_ready = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'h40800000 + (32'(i) << 20);
      set_req(a, 32'h3F000000, 0, 5'(16 + i), model(a, 32'h3F000000, 0), 1);
      cyc();
    end
    set_req(32'h41000000, 32'h41000000, 1, 30, 32'h00000000, 1);
    repeat (5) cyc();
    a0 = n_acc;
    bus.rsp_ready = 1;
    chk("fp_ready_low", 32'(bus.req_ready), 0);
    cyc();
    chk("fp_no_accept", 32'(n_acc - a0), 0);
    chk("fp_outstanding7", 32'(dut.outstanding_q), 7);
    chk("fp_ready_high", 32'(bus.req_ready), 1);
    cyc();
    chk("fp_accept_next", 32'(n_acc - a0), 1);
    drain();

    // async reset with 2 buffered and 3 in flight
    bus.rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      a = 32'h3FC00000 + (32'(i) << 23);
      set_req(a, 32'h3F800000, 0, 5'(i), model(a, 32'h3F800000, 0), 1);
      cyc();
    end
    bus.req_valid = 0;
    cyc();
    chk("ar_pre_valid", 32'(bus.rsp_valid), 1);
    #2 reset = 1;
    #1;
    chk("ar_rsp_valid_now", 32'(bus.rsp_valid), 0);
    chk("ar_fa_op1_now", fa_op1, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    bus.rsp_ready = 1;
    chk("ar_req_ready", 32'(bus.req_ready), 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("ar_no_stale", 32'(bus.rsp_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fadd_issue.md
# fadd_issue

Issue/retire controller directly upstream of the pipelined `fadd` unit. Accepts add/subtract requests on a valid/ready port and drives `fadd` operands. Tracks each operation through the fixed-latency pipeline with a valid/tag shift register. Captures results into an in-order response FIFO, with credit-based admission so the FIFO can never overflow while `fadd` itself never stalls.

## Interface
- `LAT`, 3: `fadd` latency in cycles, from operands stable on `fa_op1`/`fa_op2` to the matching `fa_result`.
- `DEPTH`, 8: response FIFO entries, power of two, ≥ 2; also the cap on outstanding operations.
- `TAG_W`, 5: request tag width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready` at a rising edge.
- `req_op1` in 32: IEEE-754 single operand A.
- `req_op2` in 32: IEEE-754 single operand B.
- `req_sub` in 1: 1 = A − B, 0 = A + B.
- `req_tag` in TAG_W: returned with the result.
- `fa_op1` out 32: to `fadd` op1.
- `fa_op2` out 32: to `fadd` op2.
- `fa_result` in 32: from `fadd` result.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: pop when `rsp_valid & rsp_ready` at a rising edge.
- `rsp_result` out 32: head result.
- `rsp_tag` out TAG_W: head tag.

## Operation
**Accept**
- On accept, `fa_op1 <= req_op1` and `fa_op2 <= {req_op2[31] ^ req_sub, req_op2[30:0]}`.
- The sign flip is applied unconditionally, including to NaN, Inf and zero. No other FP handling is done here.
- `fa_op1`/`fa_op2` hold their value when there is no accept.

**Tracking**
- Shift register of LAT+1 stages, each stage holding {valid, tag}.
- Stage 0 loads {accept, req_tag} every cycle; all stages shift every cycle.
- When the last stage is valid, `{fa_result, tag}` is written into the FIFO that cycle.

**FIFO**
- In-order, DEPTH entries.
- `rsp_valid` = not empty. `rsp_result`/`rsp_tag` = head entry.
- A write and a pop in the same cycle are both performed.

**Credits**
- Register `outstanding`, 0..DEPTH, counts in-flight operations plus FIFO occupancy.
- +1 on accept, −1 on pop, unchanged when both occur.
- `req_ready = (outstanding < DEPTH)`, driven from the register only.
- No combinational path from `rsp_ready` to `req_ready`: at `outstanding == DEPTH`, a same-cycle pop does not enable an accept.

**Guaranteed by the credit scheme**
- A FIFO write never occurs while the FIFO is full.
- Ordering is strict FIFO; responses never reorder.

## Timing
- **Reset values:** `req_ready` = 1 (after release), `rsp_valid` = 0, `rsp_result` = 0, `rsp_tag` = 0, `fa_op1` = 0, `fa_op2` = 0, `outstanding` = 0, all stage valids = 0, FIFO pointers = 0.
- **Reset is asynchronous:** outputs take their reset values immediately on assertion, not at the next edge.
- **Reset mid-operation:** all in-flight and buffered operations are discarded. Results still emerging from `fadd` after reset release are ignored, because their stage valid bits were cleared. No stale response may appear.
- **Latency:**
  - Accept at edge k → `fa_*` updated after edge k.
  - Result written to the FIFO at edge k+LAT+1.
  - `rsp_valid` high after edge k+LAT+1 if the FIFO was empty, i.e. 4 cycles for LAT=3.
- **Throughput:** one accept per cycle sustained when `rsp_ready` = 1 and DEPTH ≥ LAT+2. The defaults satisfy this.
- **Full:** `outstanding == DEPTH` → `req_ready` = 0 until after the edge of the next pop.
- **Empty:** no pop when `rsp_valid` = 0. `rsp_ready` is a don't-care then.
- **Wrap-around:** FIFO pointers wrap modulo DEPTH. Verify with more than 2·DEPTH operations.

## Test plan
- **Add:** 0x3F800000 + 0x40000000, tag 3, `rsp_ready` = 1 → `fa_op2` = 0x40000000; `rsp_valid` rises exactly 4 cycles after accept with `rsp_result` = 0x40400000 and `rsp_tag` = 3, held for one cycle.
- **Subtract:** 0x40400000 − 0x3F800000 (`req_sub` = 1) → `fa_op2` = 0xBF800000; `rsp_result` = 0x40000000.
- **Backpressure:** `rsp_ready` = 0, 10 back-to-back requests with tags 0..9 → exactly 8 accepted and `req_ready` = 0 after the 8th accept. Then raise `rsp_ready` → 8 responses, tags 0..7 in order, `req_ready` = 1 one edge after the first pop, and tags 8, 9 are then accepted.
- **Streaming:** `rsp_ready` = 1 with 100 random operand pairs → `req_ready` never drops, one response per cycle, in order. Each result is checked against the shortreal model within 1 ulp or bit-exact.
- **Full plus pop:** fill to `outstanding` = 8, then `req_valid` = 1 with `rsp_ready` = 1 in the same cycle → no accept that cycle; `outstanding` = 7 after the edge and the accept happens the following cycle.
- **Async reset:** 3 operations in flight and 2 buffered, assert `reset` between edges → `rsp_valid` = 0 immediately. After release, `req_ready` = 1 and no `rsp_valid` for 10 cycles.
